// File: rtl/vec_mem_seq_if.sv
// Bundle of the pipeline-side request/response signals and the single-port
// RAM signals for the vector memory sequencer.
interface vec_mem_seq_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic                           req_i;
  logic                           we_i;
  logic                           vs_i;
  logic [ADDR_W-1:0]              addr_i;
  logic [LANES-1:0][DATA_W-1:0]   wdata_i;
  logic [LANES-1:0][DATA_W-1:0]   rdata_o;
  logic                           busy_o;
  logic                           done_o;
  logic [ADDR_W-1:0]              ram_addr_o;
  logic [DATA_W-1:0]              ram_wdata_o;
  logic                           ram_we_o;
  logic [DATA_W-1:0]              ram_rdata_i;

  // Environment side: issues requests and plays the RAM.
  modport master (
    output req_i, we_i, vs_i, addr_i, wdata_i, ram_rdata_i,
    input  rdata_o, busy_o, done_o, ram_addr_o, ram_wdata_o, ram_we_o
  );

  // Sequencer side.
  modport slave (
    input  req_i, we_i, vs_i, addr_i, wdata_i, ram_rdata_i,
    output rdata_o, busy_o, done_o, ram_addr_o, ram_wdata_o, ram_we_o
  );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector/scalar load-store sequencer: serialises a LANES-wide access into
// one-word-per-cycle transfers on a single-port synchronous-read RAM.
module vec_mem_seq #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic          clk,
  input  logic          rst,
  vec_mem_seq_if.slave  bus
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [CNT_W-1:0]             r_cnt;
  logic [ADDR_W-1:0]            r_base;
  logic                         r_we;
  logic                         r_vs;
  logic [LANES-1:0][DATA_W-1:0] r_wbuf;
  logic [LANES-1:0][DATA_W-1:0] r_rdata;

  logic [CNT_W-1:0]             w_last_cnt;
  logic                         w_last;
  logic [CNT_W-1:0]             w_wr_lane;
  logic [CNT_W-1:0]             w_rd_lane;
  logic [CNT_W-1:0]             w_drain_lane;
  logic [ADDR_W-1:0]            w_elem_addr;

  // Element i lives in lane LANES-1-i; a scalar uses only the top lane.
  assign w_last_cnt   = r_vs ? CNT_W'(LANES - 1) : '0;
  assign w_last       = (r_cnt == w_last_cnt);
  assign w_wr_lane    = CNT_W'(LANES - 1) - r_cnt;
  // Read data arrives one cycle late, so it belongs to element count-1.
  assign w_rd_lane    = CNT_W'(LANES) - r_cnt;
  assign w_drain_lane = r_vs ? '0 : CNT_W'(LANES - 1);
  // Plain modular add gives the required address wrap.
  assign w_elem_addr  = r_base + ADDR_W'(r_cnt);

  assign bus.rdata_o  = r_rdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore output decode from the registered state.
  always_comb begin
    w_state_next    = r_state;
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          w_state_next = bus.we_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        bus.busy_o      = 1'b1;
        bus.ram_we_o    = r_we;
        bus.ram_addr_o  = w_elem_addr;
        bus.ram_wdata_o = r_wbuf[w_wr_lane];
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_READ: begin
        bus.busy_o     = 1'b1;
        bus.ram_addr_o = w_elem_addr;
        if (w_last) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.busy_o   = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        bus.done_o   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request capture, element counter and load-data lane capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_vs    <= 1'b0;
      r_wbuf  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_i) begin
            r_base <= bus.addr_i;
            r_wbuf <= bus.wdata_i;
            r_we   <= bus.we_i;
            r_vs   <= bus.vs_i;
            r_cnt  <= '0;
          end
        end
        S_WRITE: begin
          if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (r_cnt != '0) begin
            r_rdata[w_rd_lane] <= bus.ram_rdata_i;
          end
          if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          r_rdata[w_drain_lane] <= bus.ram_rdata_i;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed self-checking bench for vec_mem_seq with a behavioural
// synchronous-read RAM and a write log.
module tb_vec_mem_seq;

  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;

  logic clk;
  logic rst;

  vec_mem_seq_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  vec_mem_seq #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];
  int                log_cyc  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, write on the rising edge; every write logged.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we_o) begin
      mem[bus.ram_addr_o] <= bus.ram_wdata_o;
      log_addr.push_back(bus.ram_addr_o);
      log_data.push_back(bus.ram_wdata_o);
      log_cyc.push_back(cyc);
    end
    bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  // Drives one request and counts cycles after acceptance up to done_o.
  task automatic do_txn(input bit we, input bit vs, input logic [ADDR_W-1:0] addr,
                        input logic [LANES-1:0][DATA_W-1:0] wd, output int lat);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.vs_i    = vs;
    bus.addr_i  = addr;
    bus.wdata_i = wd;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.vs_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    n_cmp++; if (bus.ram_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", bus.ram_we_o); end
    n_cmp++; if (bus.ram_addr_o !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", bus.ram_addr_o); end
    n_cmp++; if (bus.ram_wdata_o !== '0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", bus.ram_wdata_o); end
    n_cmp++; if (bus.rdata_o !== '0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.rdata_o); end
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_vector_store();
    logic [LANES-1:0][DATA_W-1:0] wd;
    int lat;
    for (int i = 0; i < LANES; i++) wd[LANES-1-i] = DATA_W'(i + 1);
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    do_txn(1'b1, 1'b1, 13'h010, wd, lat);
    n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL vst_latency got %0d want 17", lat); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL vst_busy_in_done got %b want 0", bus.busy_o); end
    n_cmp++; if (log_addr.size() != 16) begin n_bad++; $display("FAIL vst_nwrites got %0d want 16", log_addr.size()); end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== 13'(16'h010 + i) || log_data[i] !== DATA_W'(i + 1)) begin
        n_bad++; $display("FAIL vst_write[%0d] got addr %h data %h want addr %h data %h",
                          i, log_addr[i], log_data[i], 13'(16'h010 + i), i + 1);
      end
      n_cmp++; if (log_cyc[i] != log_cyc[0] + i) begin
        n_bad++; $display("FAIL vst_consecutive[%0d] got cycle %0d want %0d", i, log_cyc[i], log_cyc[0] + i);
      end
    end
    n_cmp++; if (bus.rdata_o !== '0) begin n_bad++; $display("FAIL vst_rdata_untouched got %h want 0", bus.rdata_o); end
    $display("test_vector_store base 010 latency %0d writes %0d", lat, log_addr.size());
  endtask

  task automatic test_vector_load();
    int lat;
    do_txn(1'b0, 1'b1, 13'h010, '0, lat);
    n_cmp++; if (lat != 18) begin n_bad++; $display("FAIL vld_latency got %0d want 18", lat); end
    for (int i = 0; i < LANES; i++) begin
      n_cmp++; if (bus.rdata_o[LANES-1-i] !== DATA_W'(i + 1)) begin
        n_bad++; $display("FAIL vld_lane[%0d] got %h want %h", LANES-1-i, bus.rdata_o[LANES-1-i], i + 1);
      end
    end
    $display("test_vector_load base 010 latency %0d", lat);
  endtask

  task automatic test_scalar_store();
    logic [LANES-1:0][DATA_W-1:0] wd;
    int lat;
    for (int i = 0; i < LANES; i++) wd[i] = 32'h5555_0000 + DATA_W'(i);
    wd[LANES-1] = 32'hDEAD_BEEF;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    do_txn(1'b1, 1'b0, 13'h100, wd, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL sst_latency got %0d want 2", lat); end
    n_cmp++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL sst_nwrites got %0d want 1", log_addr.size()); end
    if (log_addr.size() >= 1) begin
      n_cmp++; if (log_addr[0] !== 13'h100 || log_data[0] !== 32'hDEAD_BEEF) begin
        n_bad++; $display("FAIL sst_write got addr %h data %h want addr 100 data deadbeef", log_addr[0], log_data[0]);
      end
    end
    n_cmp++; if (bus.rdata_o[LANES-1] !== 32'd1) begin n_bad++; $display("FAIL sst_rdata_untouched got %h want 1", bus.rdata_o[LANES-1]); end
    $display("test_scalar_store addr 100 latency %0d", lat);
  endtask

  task automatic test_scalar_load();
    int lat;
    do_txn(1'b0, 1'b0, 13'h100, '0, lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL sld_latency got %0d want 3", lat); end
    n_cmp++; if (bus.rdata_o[LANES-1] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL sld_lane15 got %h want deadbeef", bus.rdata_o[LANES-1]);
    end
    for (int l = 0; l < LANES-1; l++) begin
      n_cmp++; if (bus.rdata_o[l] !== DATA_W'(LANES - l)) begin
        n_bad++; $display("FAIL sld_lane_hold[%0d] got %h want %h", l, bus.rdata_o[l], LANES - l);
      end
    end
    $display("test_scalar_load addr 100 latency %0d", lat);
  endtask

  task automatic test_wrap();
    logic [LANES-1:0][DATA_W-1:0] wd;
    logic [ADDR_W-1:0] exp_addr;
    int lat;
    for (int i = 0; i < LANES; i++) wd[LANES-1-i] = 32'h0000_0100 + DATA_W'(i);
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    do_txn(1'b1, 1'b1, 13'h1FFE, wd, lat);
    n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL wrap_latency got %0d want 17", lat); end
    n_cmp++; if (log_addr.size() != 16) begin n_bad++; $display("FAIL wrap_nwrites got %0d want 16", log_addr.size()); end
    exp_addr = 13'h1FFE;
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== exp_addr) begin
        n_bad++; $display("FAIL wrap_addr[%0d] got %h want %h", i, log_addr[i], exp_addr);
      end
      exp_addr = exp_addr + 13'd1;
    end
    $display("test_wrap base 1ffe latency %0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.vs_i = 1'b1; bus.addr_i = 13'h300;
    for (int i = 0; i < LANES; i++) bus.wdata_i[i] = 32'hA000_0000 + DATA_W'(i);
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.ram_we_o !== 1'b1 || bus.ram_addr_o !== 13'h305) begin
      n_bad++; $display("FAIL rmid_pre got we %b addr %h want we 1 addr 305", bus.ram_we_o, bus.ram_addr_o);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.ram_we_o !== 1'b0) begin n_bad++; $display("FAIL rmid_we got %b want 0", bus.ram_we_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.rdata_o !== '0) begin n_bad++; $display("FAIL rmid_rdata got %h want 0", bus.rdata_o); end
    n_cmp++; if (bus.ram_addr_o !== '0) begin n_bad++; $display("FAIL rmid_addr got %h want 0", bus.ram_addr_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (log_addr.size() != 5) begin n_bad++; $display("FAIL rmid_nwrites got %0d want 5", log_addr.size()); end
    rst = 1'b1;
    do_txn(1'b0, 1'b0, 13'h010, '0, lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL rmid_post_latency got %0d want 3", lat); end
    n_cmp++; if (bus.rdata_o[LANES-1] !== 32'd1 || bus.rdata_o[LANES-2:0] !== '0) begin
      n_bad++; $display("FAIL rmid_post_rdata got %h want lane15=1 others 0", bus.rdata_o);
    end
    $display("test_reset_mid writes before reset %0d post latency %0d", log_addr.size(), lat);
  endtask

  task automatic test_back_to_back();
    int  n_done;
    int  n_viol;
    bit  prev_done;
    n_done = 0; n_viol = 0; prev_done = 1'b0;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.vs_i = 1'b0; bus.addr_i = 13'h010;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (prev_done && (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0)) n_viol++;
      if (bus.done_o === 1'b1) n_done++;
      prev_done = (bus.done_o === 1'b1);
    end
    bus.req_i = 1'b0;
    n_cmp++; if (n_done != 10) begin n_bad++; $display("FAIL b2b_count got %0d want 10", n_done); end
    n_cmp++; if (n_viol != 0) begin n_bad++; $display("FAIL b2b_idle_gap got %0d violations want 0", n_viol); end
    n_cmp++; if (bus.rdata_o[LANES-1] !== 32'd1) begin n_bad++; $display("FAIL b2b_rdata got %h want 1", bus.rdata_o[LANES-1]); end
    $display("test_back_to_back completions %0d gap violations %0d", n_done, n_viol);
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_vector_store();
    test_vector_load();
    test_scalar_store();
    test_scalar_load();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 SHALL have parameter LANES, default 16, number of 32-bit vector lanes.
REQ-002 SHALL have parameter DATA_W, default 32, lane and RAM word width.
REQ-003 SHALL have parameter ADDR_W, default 13, word address width.
REQ-004 SHALL provide port clk  in  1  single clock; all state changes occur on the rising edge.
REQ-005 SHALL provide port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide port req_i  in  1  access request from the EM pipeline register; sampled only in IDLE.
REQ-007 SHALL provide port we_i  in  1  1 = store, 0 = load.
REQ-008 SHALL provide port vs_i  in  1  1 = vector (LANES words), 0 = scalar (1 word).
REQ-009 SHALL provide port addr_i  in  ADDR_W  base word address.
REQ-010 SHALL provide port wdata_i  in  LANES x DATA_W  store data, packed [LANES-1:0][DATA_W-1:0].
REQ-011 SHALL provide port rdata_o  out  LANES x DATA_W  load data to the MW pipeline register.
REQ-012 SHALL provide port busy_o  out  1  transaction in progress.
REQ-013 SHALL provide port done_o  out  1  one-cycle completion pulse.
REQ-014 SHALL provide port ram_addr_o  out  ADDR_W  single-port RAM word address.
REQ-015 SHALL provide port ram_wdata_o  out  DATA_W  RAM write data.
REQ-016 SHALL provide port ram_we_o  out  1  RAM write enable.
REQ-017 SHALL provide port ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after the address is presented (synchronous read).

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE; all outputs SHALL be Moore (decoded from registered state only).
REQ-019 In IDLE with req_i=1, SHALL latch addr_i, wdata_i, we_i, vs_i, clear the 4-bit element counter, and enter WRITE if we_i=1, else READ.
REQ-020 SHALL use element count N = LANES if vs_i=1, else N = 1.
REQ-021 Element i SHALL map to address (base+i) mod 2^ADDR_W and to lane [LANES-1-i]; lane [LANES-1] is the scalar lane.
REQ-022 In WRITE: ram_we_o=1, ram_addr_o=base+count, ram_wdata_o=wbuf[LANES-1-count]; count increments each cycle; at count=N-1 SHALL go to DONE.
REQ-023 In READ: ram_we_o=0, ram_addr_o=base+count; from the second READ cycle onward SHALL capture ram_rdata_i into lane [LANES-1-(count-1)]; at count=N-1 SHALL go to DRAIN.
REQ-024 In DRAIN: SHALL capture ram_rdata_i into lane [LANES-N], then go to DONE.
REQ-025 In DONE: done_o=1 for exactly one cycle, then go to IDLE.
REQ-026 busy_o SHALL be 1 in WRITE, READ and DRAIN, and 0 in IDLE and DONE.
REQ-027 Latency from the accepting edge to done_o: vector store 17 cycles, vector load 18 cycles, scalar store 2 cycles, scalar load 3 cycles.
REQ-028 Scalar load SHALL modify only rdata_o[LANES-1]; all other lanes SHALL hold their prior values.
REQ-029 rdata_o SHALL remain stable from DONE until the next load captures data; stores SHALL NOT alter rdata_o.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-031 req_i in any state other than IDLE SHALL be ignored; there is no queueing.
REQ-032 Outside WRITE, ram_we_o=0 and ram_wdata_o=0; outside WRITE and READ, ram_addr_o=0.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, counter=0, latched request fields=0, rdata_o=0, busy_o=0, done_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, including when asserted mid-transaction.
REQ-034 After rst deasserts, the first rising edge with req_i=1 SHALL be accepted normally.

Verification
REQ-035 Vector store: base 0x010, wdata[15-i]=i+1 -> RAM writes 0x010..0x01F with data 1..16 on consecutive cycles; done_o pulses 17 cycles after accept.
REQ-036 Vector load of the same block -> rdata_o[15-i]=i+1 for all i; done_o pulses 18 cycles after accept.
REQ-037 Scalar load at 0x100 with RAM=0xDEADBEEF -> rdata_o[15]=0xDEADBEEF, lanes 14..0 unchanged; done_o pulses 3 cycles after accept.
REQ-038 Vector store at base 0x1FFE -> ram_addr_o sequence 0x1FFE, 0x1FFF, 0x0000 .. 0x000D.
REQ-039 Assert rst=0 at count=5 of a vector store -> ram_we_o=0 and busy_o=0 with no clock edge; rdata_o=0; no further writes occur.
REQ-040 req_i held high for 40 cycles -> back-to-back transactions, each starting only from IDLE (one idle cycle after each DONE); no request accepted while busy_o=1.
